// File: rtl/gpio_reg_bank_if.sv
// BRAM port bundle between the register bank (master) and the BRAM controller port (slave).
interface gpio_reg_bank_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32
);
   logic                    BRAM_clk;
   logic                    BRAM_rst;
   logic [ADDR_WIDTH-1:0]   BRAM_addr;
   logic                    BRAM_en;
   logic [DATA_WIDTH/8-1:0] BRAM_we;
   logic [DATA_WIDTH-1:0]   BRAM_wrdata;
   logic [DATA_WIDTH-1:0]   BRAM_rddata;
   logic                    BRAM_busy;

   modport master (
      output BRAM_clk, BRAM_rst, BRAM_addr, BRAM_en, BRAM_we, BRAM_wrdata,
      input  BRAM_rddata, BRAM_busy
   );

   modport slave (
      input  BRAM_clk, BRAM_rst, BRAM_addr, BRAM_en, BRAM_we, BRAM_wrdata,
      output BRAM_rddata, BRAM_busy
   );
endinterface

// File: rtl/gpio_reg_bank.sv
// GPIO register bank: sweeps a BRAM window, pushing input registers into BRAM and
// mirroring output registers from BRAM, one register per slot.
module gpio_reg_bank #(
   parameter int                  NUM_REGS   = 32,
   parameter int                  DATA_WIDTH = 32,
   parameter int                  ADDR_WIDTH = 11,
   parameter int                  BASE_ADDR  = 0,
   parameter logic [NUM_REGS-1:0] INPUT_MASK = {NUM_REGS{1'b0}},
   parameter int                  RD_LATENCY = 1,
   parameter int                  SCAN_GAP   = 0
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   gpio_reg_bank_if.master                bram,
   input  logic                           scan_en,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] in_bus,
   output logic [NUM_REGS*DATA_WIDTH-1:0] out_bus,
   output logic [NUM_REGS-1:0]            out_update,
   output logic                           scan_done
);
   localparam int                    IDX_W    = $clog2(NUM_REGS);
   localparam int                    BE_W     = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [1:0]            LAT_LOAD = 2'(RD_LATENCY);
   localparam logic [3:0]            GAP_LOAD = 4'(SCAN_GAP);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [IDX_W-1:0]      idx;
   logic [1:0]            lat_cnt;
   logic [3:0]            gap_cnt;
   logic                  aborted;

   logic [DATA_WIDTH-1:0] in_arr  [NUM_REGS];
   logic [DATA_WIDTH-1:0] out_arr [NUM_REGS];

   logic                  is_input;
   logic [DATA_WIDTH-1:0] cur_in;
   logic                  issue_fire;
   logic                  wait_last;
   logic                  gap_last;
   logic                  slot_end;
   logic                  abort_eff;
   logic                  capture;

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_slice
         assign in_arr[g]                              = in_bus[g*DATA_WIDTH +: DATA_WIDTH];
         assign out_bus[g*DATA_WIDTH +: DATA_WIDTH]    = out_arr[g];
      end
   endgenerate

   assign bram.BRAM_clk  = aclk;
   assign bram.BRAM_rst  = ~aresetn;
   assign bram.BRAM_addr = BASE + ADDR_WIDTH'(idx);

   assign is_input   = INPUT_MASK[idx];
   assign cur_in     = in_arr[idx];
   assign issue_fire = (state == ISSUE) && !bram.BRAM_busy;
   assign wait_last  = (state == WAIT) && (lat_cnt == 2'd1);
   assign gap_last   = (state == GAP) && (gap_cnt == 4'd1);
   assign slot_end   = (SCAN_GAP == 0) ? wait_last : gap_last;
   // A slot is retried if the other side grabbed the BRAM at any point while waiting.
   assign abort_eff  = aborted || ((state == WAIT) && bram.BRAM_busy);
   assign capture    = wait_last && !is_input && !bram.BRAM_busy && !aborted;

   // State register.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: ISSUE -> WAIT (RD_LATENCY) -> optional GAP -> next slot or park.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (scan_en && !bram.BRAM_busy) begin
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         ISSUE: begin
            if (bram.BRAM_busy) begin
               state_nxt = ISSUE;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (!wait_last) begin
               state_nxt = WAIT;
            end else if (SCAN_GAP != 0) begin
               state_nxt = GAP;
            end else if (scan_en) begin
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         GAP: begin
            if (!gap_last) begin
               state_nxt = GAP;
            end else if (scan_en) begin
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // BRAM access strobes are driven only in ISSUE and suppressed while the port is busy.
   always_comb begin
      bram.BRAM_en     = 1'b0;
      bram.BRAM_we     = {BE_W{1'b0}};
      bram.BRAM_wrdata = {DATA_WIDTH{1'b0}};
      if (state == ISSUE) begin
         bram.BRAM_en = ~bram.BRAM_busy;
         if (is_input) begin
            bram.BRAM_we     = {BE_W{~bram.BRAM_busy}};
            bram.BRAM_wrdata = cur_in;
         end else begin
            bram.BRAM_we     = {BE_W{1'b0}};
            bram.BRAM_wrdata = {DATA_WIDTH{1'b0}};
         end
      end else begin
         bram.BRAM_en     = 1'b0;
         bram.BRAM_we     = {BE_W{1'b0}};
         bram.BRAM_wrdata = {DATA_WIDTH{1'b0}};
      end
   end

   // Slot datapath: counters, abort flag, loopback/capture, change strobes and index advance.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         idx        <= {IDX_W{1'b0}};
         lat_cnt    <= 2'd0;
         gap_cnt    <= 4'd0;
         aborted    <= 1'b0;
         out_update <= {NUM_REGS{1'b0}};
         scan_done  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            out_arr[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         out_update <= {NUM_REGS{1'b0}};
         scan_done  <= 1'b0;

         if (issue_fire) begin
            lat_cnt <= LAT_LOAD;
            aborted <= 1'b0;
            if (is_input) begin
               out_arr[idx] <= cur_in;
            end
         end

         if (state == WAIT) begin
            lat_cnt <= lat_cnt - 2'd1;
            if (bram.BRAM_busy) begin
               aborted <= 1'b1;
            end
            if (wait_last) begin
               gap_cnt <= GAP_LOAD;
            end
            if (capture) begin
               out_arr[idx] <= bram.BRAM_rddata;
               if (bram.BRAM_rddata != out_arr[idx]) begin
                  out_update[idx] <= 1'b1;
               end
            end
         end

         if (state == GAP) begin
            gap_cnt <= gap_cnt - 4'd1;
         end

         if (slot_end && !abort_eff) begin
            if (idx == LAST_IDX) begin
               idx       <= {IDX_W{1'b0}};
               scan_done <= 1'b1;
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end
      end
   end
endmodule

// File: doc/gpio_reg_bank.md
Name: gpio_reg_bank

Overview:
- Parametrised successor to the fixed 20-register GPIO/BRAM mirror.
- Continuously sweeps a window of a shared 32-bit BRAM:
  - writes "input" registers from fabric into BRAM;
  - reads "output" registers from BRAM into fabric.
- Adds over the previous generation:
  - packed buses of arbitrary register count;
  - configurable BRAM read latency, inter-access gap and base address;
  - per-register change strobes, sweep-complete pulse and scan enable;
  - busy-abort with retry, and loopback of input registers.
- Sits between the PS-visible AXI BRAM controller port and the modem control/status fabric.

Parameters:
- NUM_REGS, 32: number of registers in the bank (2..256).
- DATA_WIDTH, 32: register and BRAM data width; multiple of 8.
- ADDR_WIDTH, 11: BRAM word-address width.
- BASE_ADDR, 0: BRAM word address of register 0. BASE_ADDR+NUM_REGS <= 2^ADDR_WIDTH.
- INPUT_MASK, all 0 (NUM_REGS bits): bit i=1 means register i is fabric->BRAM (input); bit i=0 means BRAM->fabric (output).
- RD_LATENCY, 1: BRAM read latency in cycles (1..3).
- SCAN_GAP, 0: idle cycles inserted after each slot (0..15).

Ports:
- aclk, in, 1: single clock for everything.
- aresetn, in, 1: synchronous active-low reset.
- BRAM_clk, out, 1: equals aclk.
- BRAM_rst, out, 1: equals ~aresetn.
- BRAM_addr, out, ADDR_WIDTH: BASE_ADDR+idx.
- BRAM_en, out, 1: access strobe.
- BRAM_we, out, DATA_WIDTH/8: byte write enables.
- BRAM_wrdata, out, DATA_WIDTH: write data.
- BRAM_rddata, in, DATA_WIDTH: read data.
- BRAM_busy, in, 1: BRAM port owned by the other side; no access allowed.
- scan_en, in, 1: sweep enable.
- in_bus, in, NUM_REGS*DATA_WIDTH: slice i is register i fabric value.
- out_bus, out, NUM_REGS*DATA_WIDTH: slice i is register i mirrored value.
- out_update, out, NUM_REGS: one-cycle change strobe per output register.
- scan_done, out, 1: one-cycle pulse at the end of each full sweep.

Behaviour:
- Clock and reset: one clock aclk. Reset aresetn is synchronous and active-low. Reset mid-operation abandons any access in flight.
- Reset values:
  - state IDLE, idx 0;
  - BRAM_en 0, BRAM_we 0, BRAM_wrdata 0;
  - out_bus all 0, out_update 0, scan_done 0.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - BRAM_en is 0.
  - Go to ISSUE when scan_en=1 and BRAM_busy=0.
- ISSUE (outputs are combinational from state):
  - BRAM_en = ~BRAM_busy and BRAM_addr = BASE_ADDR+idx.
  - For an input register: BRAM_we all ones and BRAM_wrdata = in_bus slice idx sampled this cycle.
  - For an output register: BRAM_we = 0 and BRAM_wrdata = 0.
  - If BRAM_busy=1, hold in ISSUE with no access.
  - Otherwise go to WAIT and load the latency counter with RD_LATENCY.
  - On the same edge, an input register's out_bus slice loads the written value (loopback); no out_update for it.
- WAIT:
  - Lasts RD_LATENCY cycles with BRAM_en=0.
  - On the last WAIT cycle, for an output register with BRAM_busy=0: capture BRAM_rddata into out_bus slice idx. If the new value differs from the old, pulse out_update[idx] for one cycle, aligned with the new out_bus value.
  - If BRAM_busy=1 in any WAIT cycle, mark the slot aborted: no capture, idx not advanced, the same register is retried.
- GAP:
  - Lasts SCAN_GAP cycles; skipped entirely when SCAN_GAP=0.
  - At exit from the slot, if not aborted, idx advances.
  - Wrap-around: idx = NUM_REGS-1 wraps to 0 and scan_done pulses for one cycle.
  - Then go to ISSUE if scan_en=1, else to IDLE. scan_en low only parks between slots; it never truncates a slot.
- Slot period, no busy: 1 + RD_LATENCY + SCAN_GAP cycles. Sweep length = NUM_REGS × slot period.
- out_update bits are never asserted for input-mask registers or for aborted reads.
- Widths: idx is ceil(log2(NUM_REGS)) bits; BRAM_addr is BASE_ADDR+idx truncated to ADDR_WIDTH.

Test Plan:
- Baseline: NUM_REGS=4, INPUT_MASK=4'b0101, RD_LATENCY=1, SCAN_GAP=0, BRAM preloaded reg1=0xDEADBEEF, reg3=0x12345678, in_bus reg0=0xA5A5A5A5, reg2=0x0000FFFF, scan_en=1 → addr sequence 0,1,2,3,0 with BRAM_en every 2nd cycle; BRAM_we=4'hF only at addr 0 and 2 with matching wrdata; out_update[1] and out_update[3] each pulse once; scan_done pulses 8 cycles after the first ISSUE.
- Second sweep, BRAM unchanged → no out_update pulses. Then change BRAM reg3 to 0x1 → only out_update[3] pulses, next sweep.
- BRAM_busy held high for 5 cycles during reg1 WAIT → no capture, reg1 reissued after busy drops, out_bus slice1 = BRAM value, exactly one out_update[1].
- RD_LATENCY=3, SCAN_GAP=2 → slot period 6; capture lands exactly 3 cycles after BRAM_en; 24-cycle sweep.
- aresetn low for 1 cycle while in WAIT of reg3 → next cycle BRAM_en=0 and out_bus=0. Restart at addr BASE_ADDR+0.
- scan_en dropped mid-slot → slot completes, FSM parks in IDLE with BRAM_en=0. Re-asserting scan_en resumes at the next idx, not 0.
